// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcode constants,
// fetch FSM encoding, reset defaults and a small decode helper.
package inst_fetch_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,  // request outstanding at pc
    ST_HOLD    = 2'd1,  // word buffered, waiting for downstream room
    ST_BR_WAIT = 2'd2,  // control transfer pending, waiting for ROB redirect
    ST_FLUSH   = 2'd3   // stale request outstanding, its word will be dropped
  } fetch_state_t;

  // Control transfers whose target only the back end can resolve.
  function automatic logic waits_for_redirect(input logic [6:0] opcode);
    return (opcode == OP_BRANCH) || (opcode == OP_JALR);
  endfunction

endpackage

// File: rtl/inst_fetch_imm_gen.sv
// Immediate generator: builds the sign/zero-extended immediate of a raw
// instruction word. Shared by the JAL target adder and the output register.
module imm_gen
  import inst_fetch_pkg::*;
(
  input  logic [31:0] i_ins,
  output logic [31:0] o_imm
);

  // Select the immediate format from the opcode; R-type and unknown give 0.
  always_comb begin
    // NOTE: default first so every path assigns o_imm and no latch is inferred.
    o_imm = '0;
    case (i_ins[6:0])
      OP_LOAD, OP_JALR: o_imm = {{20{i_ins[31]}}, i_ins[31:20]};
      OP_IMM: begin
        // Shift-immediates carry only a 5-bit unsigned shamt.
        if ((i_ins[14:12] == 3'b001) || (i_ins[14:12] == 3'b101))
          o_imm = {27'b0, i_ins[24:20]};
        else
          o_imm = {{20{i_ins[31]}}, i_ins[31:20]};
      end
      OP_STORE:         o_imm = {{20{i_ins[31]}}, i_ins[31:25], i_ins[11:7]};
      OP_BRANCH:        o_imm = {{19{i_ins[31]}}, i_ins[31], i_ins[7], i_ins[30:25],
                                 i_ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC: o_imm = {i_ins[31:12], 12'b0};
      OP_JAL:           o_imm = {{11{i_ins[31]}}, i_ins[31], i_ins[19:12], i_ins[20],
                                 i_ins[30:21], 1'b0};
      OP_REG:           o_imm = '0;
      default:          o_imm = '0;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the PC, issues one word request at a time,
// hands each accepted word to the decoder with its immediate and PC, resolves
// JAL locally and parks on branches/JALR until the ROB redirects.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_valid,
  input  logic [XLEN-1:0] mem_data,
  input  logic            stall,
  input  logic            pc_bc_flag,
  input  logic [XLEN-1:0] pc_bc,
  output logic [XLEN-1:0] ins,
  output logic            ins_flag,
  output logic [XLEN-1:0] ins_imm,
  output logic [XLEN-1:0] rd_val
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  fetch_state_t    w_step_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_step_pc;
  logic [XLEN-1:0] r_req_addr;
  logic [XLEN-1:0] w_addr_nxt;
  logic            r_mem_req;
  logic            w_req_nxt;
  logic [XLEN-1:0] r_buf;
  logic [XLEN-1:0] r_ins;
  logic [XLEN-1:0] r_ins_imm;
  logic [XLEN-1:0] r_rd_val;
  logic            r_ins_flag;
  logic            w_emit;
  logic            w_latch;
  logic            w_resp;
  logic [XLEN-1:0] w_word;
  logic [XLEN-1:0] w_imm;

  // A response only counts while our request is actually on the bus.
  assign w_resp = mem_valid & r_mem_req;

  // The word being accepted: the buffered one in HOLD, otherwise the bus.
  assign w_word = (r_state == ST_HOLD) ? r_buf : mem_data;

  imm_gen u_imm_gen (
    .i_ins (w_word),
    .o_imm (w_imm)
  );

  // Next PC and state after accepting w_word.
  always_comb begin
    w_step_pc    = r_pc + XLEN'(4);
    w_step_state = ST_FETCH;
    if (w_word[6:0] == OP_JAL) begin
      w_step_pc = r_pc + w_imm;
    end else if (waits_for_redirect(w_word[6:0])) begin
      w_step_pc    = r_pc;
      w_step_state = ST_BR_WAIT;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_FETCH;
    else if (rdy)
      // NOTE: non-blocking so every register updates from pre-edge values.
      r_state <= w_state_nxt;
  end

  // FSM next-state logic; a redirect overrides everything else.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_emit      = 1'b0;
    w_latch     = 1'b0;
    if (pc_bc_flag) begin
      w_pc_nxt = pc_bc;
      case (r_state)
        ST_FETCH: w_state_nxt = w_resp ? ST_FETCH : ST_FLUSH;
        ST_FLUSH: w_state_nxt = ST_FLUSH;
        default:  w_state_nxt = ST_FETCH;
      endcase
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_resp) begin
            if (stall) begin
              w_latch     = 1'b1;
              w_state_nxt = ST_HOLD;
            end else begin
              w_emit      = 1'b1;
              w_pc_nxt    = w_step_pc;
              w_state_nxt = w_step_state;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            w_emit      = 1'b1;
            w_pc_nxt    = w_step_pc;
            w_state_nxt = w_step_state;
          end
        end
        ST_BR_WAIT: w_state_nxt = ST_BR_WAIT;
        ST_FLUSH:   if (w_resp) w_state_nxt = ST_FETCH;
        default:    w_state_nxt = ST_FETCH;
      endcase
    end
  end

  // FSM outputs: request line and address for the coming cycle. FLUSH keeps
  // the stale address on the bus until its response drains.
  always_comb begin
    w_req_nxt  = (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_FLUSH);
    w_addr_nxt = (w_state_nxt == ST_FETCH) ? w_pc_nxt : r_req_addr;
  end

  // PC, bus request and holding buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_buf      <= '0;
    end else if (rdy) begin
      r_pc       <= w_pc_nxt;
      r_req_addr <= w_addr_nxt;
      r_mem_req  <= w_req_nxt;
      if (w_latch) r_buf <= mem_data;
    end
  end

  // Decoder handoff registers; the pulse is cleared whenever rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ins_flag <= 1'b0;
      r_ins      <= '0;
      r_ins_imm  <= '0;
      r_rd_val   <= '0;
    end else if (!rdy) begin
      r_ins_flag <= 1'b0;
    end else begin
      r_ins_flag <= w_emit;
      if (w_emit) begin
        r_ins     <= w_word;
        r_ins_imm <= w_imm;
        r_rd_val  <= r_pc;
      end
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_req_addr;
  assign ins      = r_ins;
  assign ins_flag = r_ins_flag;
  assign ins_imm  = r_ins_imm;
  assign rd_val   = r_rd_val;

endmodule
